// File: rtl/mem_responder.sv
// mem_responder: byte-serial load/store data-memory responder with little-endian assembly and load extension.
// Optional misaligned-access trap enabled by defining MEM_RESP_MISALIGN_TRAP_EN.
module mem_responder #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic [2:0]              f3_q, f3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             sh_q, sh_d;
    logic [1:0]              beat_q, beat_d;
    logic                    err_q, err_d;
    logic [7:0]              mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0]   a;
    logic [1:0]              last;
    logic                    legal, trap;
    logic [31:0]             ext;
    logic                    unused;

    assign unused = ^req_addr[31:ADDR_WIDTH];
    // Wraps naturally at the top of memory because a is ADDR_WIDTH bits wide.
    assign a     = addr_q + ADDR_WIDTH'(beat_q);
    assign last  = f3_q[1] ? 2'd3 : {1'b0, f3_q[0]};
    assign legal = req_write ? (req_funct3 < 3'd3) : (req_funct3 != 3'd3 && req_funct3 < 3'd6);
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    assign trap  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign trap  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sh_d    = sh_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                f3_d    = req_funct3;
                addr_d  = req_addr[ADDR_WIDTH-1:0];
                wdata_d = req_wdata;
                beat_d  = 2'd0;
                err_d   = !legal || trap;
                state_d = err_d ? RESP : ACCESS;
            end
            ACCESS: begin
                if (!write_q)
                    sh_d[8*beat_q +: 8] = mem[a];
                beat_d  = beat_q + 2'd1;
                state_d = beat_q == last ? RESP : ACCESS;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            sh_q    <= 32'd0;
            beat_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sh_q    <= sh_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Reset forces state_q to IDLE asynchronously, which blocks any further beat writes.
    always_ff @(posedge clk)
        if (state_q == ACCESS && write_q)
            mem[a] <= wdata_q[8*beat_q +: 8];

    // funct3[2] selects zero extension; bits [1:0] select byte/half/word.
    assign ext = f3_q[1] ? sh_q :
                 f3_q[0] ? {{16{~f3_q[2] & sh_q[15]}}, sh_q[15:0]} :
                           {{24{~f3_q[2] & sh_q[7]}}, sh_q[7:0]};

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_error = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? ext : 32'd0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Expectations for the misaligned wrap store follow MEM_RESP_MISALIGN_TRAP_EN.
module tb_mem_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;
    int          passed = 0, total = 0;
    int          lat;

    mem_responder #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = ad;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'h0000_0abc;
        req_wdata = 32'h5555_5555;
    endtask

    // lat counts cycles from the accept edge to the first cycle with resp_valid.
    task automatic wait_resp(output int l);
        l = 1;
        while (!resp_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic release_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " req_ready after"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic txn(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        int l;
        send(w, f3, ad, wd);
        wait_resp(l);
        check({tag, " latency"}, l, exp_lat);
        check({tag, " rdata"}, resp_rdata, exp_rd);
        check({tag, " error"}, {31'd0, resp_error}, {31'd0, exp_err});
        release_resp(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_error", {31'd0, resp_error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        dut.mem[128] = 8'h58; dut.mem[129] = 8'h00; dut.mem[130] = 8'h00; dut.mem[131] = 8'h00;
        txn("lw128", 1'b0, 3'b010, 32'd128, 32'd0, 5, 32'h0000_0058, 1'b0);

        txn("sw123", 1'b1, 3'b010, 32'd123, 32'h1122_3344, 5, 32'd0, 1'b0);
        check("mem123", {24'd0, dut.mem[123]}, 32'h44);
        check("mem124", {24'd0, dut.mem[124]}, 32'h33);
        check("mem125", {24'd0, dut.mem[125]}, 32'h22);
        check("mem126", {24'd0, dut.mem[126]}, 32'h11);
        txn("lw123", 1'b0, 3'b010, 32'd123, 32'd0, 5, 32'h1122_3344, 1'b0);

        dut.mem[10] = 8'h80; dut.mem[11] = 8'hFF;
        txn("lb10", 1'b0, 3'b000, 32'd10, 32'd0, 2, 32'hFFFF_FF80, 1'b0);
        txn("lbu10", 1'b0, 3'b100, 32'd10, 32'd0, 2, 32'h0000_0080, 1'b0);
        txn("lh10", 1'b0, 3'b001, 32'd10, 32'd0, 3, 32'hFFFF_FF80, 1'b0);
        txn("lhu10", 1'b0, 3'b101, 32'd10, 32'd0, 3, 32'h0000_FF80, 1'b0);
        txn("sb11", 1'b1, 3'b000, 32'd11, 32'h0000_0012, 2, 32'd0, 1'b0);
        txn("lh10b", 1'b0, 3'b001, 32'd10, 32'd0, 3, 32'h0000_1280, 1'b0);

        dut.mem[12'hFFE] = 8'h00; dut.mem[12'hFFF] = 8'h00; dut.mem[0] = 8'h00; dut.mem[1] = 8'h00;
`ifdef MEM_RESP_MISALIGN_TRAP_EN
        txn("swwrap", 1'b1, 3'b010, 32'h0000_0FFE, 32'hA1B2_C3D4, 1, 32'd0, 1'b1);
        check("memFFE", {24'd0, dut.mem[12'hFFE]}, 32'h00);
        check("memFFF", {24'd0, dut.mem[12'hFFF]}, 32'h00);
        check("mem000", {24'd0, dut.mem[0]}, 32'h00);
        check("mem001", {24'd0, dut.mem[1]}, 32'h00);
        txn("lhodd", 1'b0, 3'b101, 32'd11, 32'd0, 1, 32'd0, 1'b1);
`else
        txn("swwrap", 1'b1, 3'b010, 32'h0000_0FFE, 32'hA1B2_C3D4, 5, 32'd0, 1'b0);
        check("memFFE", {24'd0, dut.mem[12'hFFE]}, 32'hD4);
        check("memFFF", {24'd0, dut.mem[12'hFFF]}, 32'hC3);
        check("mem000", {24'd0, dut.mem[0]}, 32'hB2);
        check("mem001", {24'd0, dut.mem[1]}, 32'hA1);
        txn("lwwrap", 1'b0, 3'b010, 32'h0000_0FFE, 32'd0, 5, 32'hA1B2_C3D4, 1'b0);
`endif

        send(1'b0, 3'b011, 32'd40, 32'd0);
        wait_resp(lat);
        check("ill latency", lat, 1);
        check("ill error", {31'd0, resp_error}, 32'd1);
        check("ill rdata", resp_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("ill hold valid", {31'd0, resp_valid}, 32'd1);
            check("ill hold error", {31'd0, resp_error}, 32'd1);
            check("ill hold rdata", resp_rdata, 32'd0);
            check("ill hold req_ready", {31'd0, req_ready}, 32'd0);
        end
        release_resp("ill");
        check("ill valid dropped", {31'd0, resp_valid}, 32'd0);
        txn("illst", 1'b1, 3'b100, 32'd40, 32'hFFFF_FFFF, 1, 32'd0, 1'b1);

        dut.mem[200] = 8'h11; dut.mem[201] = 8'h22; dut.mem[202] = 8'h5A; dut.mem[203] = 8'h6B;
        send(1'b1, 3'b010, 32'd200, 32'hDEAD_BEEF);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst resp_error", {31'd0, resp_error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst mem200", {24'd0, dut.mem[200]}, 32'hEF);
        check("rst mem201", {24'd0, dut.mem[201]}, 32'hBE);
        check("rst mem202", {24'd0, dut.mem[202]}, 32'h5A);
        check("rst mem203", {24'd0, dut.mem[203]}, 32'h6B);
        txn("lb200", 1'b0, 3'b000, 32'd200, 32'd0, 2, 32'hFFFF_FFEF, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
